// File: rtl/apu_pkg.sv
// Shared APU definitions: register addresses, length-counter table, triangle sequence.
// Pure constants and functions; no latency, no flow control.
// Imported by every APU channel.
package apu_pkg;

    localparam logic [1:0] REG_4008 = 2'd0;
    localparam logic [1:0] REG_4009 = 2'd1;
    localparam logic [1:0] REG_400A = 2'd2;
    localparam logic [1:0] REG_400B = 2'd3;

    function automatic logic [7:0] length_lookup(input logic [4:0] idx);
        logic [7:0] val;
        case (idx)
            5'd0:  val = 8'd10;   5'd1:  val = 8'd254;
            5'd2:  val = 8'd20;   5'd3:  val = 8'd2;
            5'd4:  val = 8'd40;   5'd5:  val = 8'd4;
            5'd6:  val = 8'd80;   5'd7:  val = 8'd6;
            5'd8:  val = 8'd160;  5'd9:  val = 8'd8;
            5'd10: val = 8'd60;   5'd11: val = 8'd10;
            5'd12: val = 8'd14;   5'd13: val = 8'd12;
            5'd14: val = 8'd26;   5'd15: val = 8'd14;
            5'd16: val = 8'd12;   5'd17: val = 8'd16;
            5'd18: val = 8'd24;   5'd19: val = 8'd18;
            5'd20: val = 8'd48;   5'd21: val = 8'd20;
            5'd22: val = 8'd96;   5'd23: val = 8'd22;
            5'd24: val = 8'd192;  5'd25: val = 8'd24;
            5'd26: val = 8'd72;   5'd27: val = 8'd26;
            5'd28: val = 8'd16;   5'd29: val = 8'd28;
            5'd30: val = 8'd32;   default: val = 8'd30;
        endcase
        return val;
    endfunction

    // Steps 0..15 descend 15..0, steps 16..31 ascend 0..15.
    function automatic logic [3:0] tri_seq(input logic [4:0] step);
        return step[4] ? step[3:0] : ~step[3:0];
    endfunction

endpackage

// File: rtl/apu_length_counter.sv
// APU length counter: table load, halt, enable clear, half-frame decrement.
// Latency: load/decrement visible on length one edge after the strobe.
// Backpressure: none; strobes are single-cycle enables and never stall.
module apu_length_counter
    import apu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [4:0] load_idx,
    input  logic       halt,
    input  logic       half_frame,
    output logic [7:0] length
);

    logic [7:0] length_q;
    logic [7:0] length_d;

    // Disable beats load beats decrement, so a coincident load drops the tick.
    always_comb begin
        length_d = length_q;
        if (!enable)
            length_d = 8'd0;
        else if (load)
            length_d = length_lookup(load_idx);
        else if (half_frame && !halt && (length_q != 8'd0))
            length_d = length_q - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            length_q <= 8'd0;
        else
            length_q <= length_d;
    end

    assign length = length_q;

endmodule

// File: rtl/triangle_channel.sv
// NES APU triangle channel: period timer, 32-step sequencer, linear and length counters.
// Latency: tr_out/length_active registered, one cycle behind step/length.
// Backpressure: none; all strobes are single-cycle enables.
module triangle_channel
    import apu_pkg::*;
#(
    parameter int TIMER_W = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_tick,
    input  logic       quarter_frame,
    input  logic       half_frame,
    input  logic       reg_wr,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_data,
    input  logic       enable,
    output logic [3:0] tr_out,
    output logic       length_active
);

    logic               ctrl_q, ctrl_d;
    logic [6:0]         lin_reload_val_q, lin_reload_val_d;
    logic               lin_reload_flag_q, lin_reload_flag_d;
    logic [6:0]         linear_q, linear_d;
    logic [TIMER_W-1:0] period_q, period_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [4:0]         step_q, step_d;
    logic [3:0]         tr_out_q, tr_out_d;
    logic               length_active_q, length_active_d;

    logic       wr_4008, wr_400a, wr_400b;
    logic       seq_run;
    logic [7:0] length;

    assign wr_4008 = reg_wr && (reg_addr == REG_4008);
    assign wr_400a = reg_wr && (reg_addr == REG_400A);
    assign wr_400b = reg_wr && (reg_addr == REG_400B);

    apu_length_counter u_len (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (wr_400b),
        .load_idx   (reg_data[7:3]),
        .halt       (ctrl_q),
        .half_frame (half_frame),
        .length     (length)
    );

    // Periods below 2 are ultrasonic; freezing the step avoids a DC pop.
    assign seq_run = (linear_q != 7'd0) && (length != 8'd0) &&
                     (period_q >= TIMER_W'(2));

    always_comb begin
        ctrl_d            = ctrl_q;
        lin_reload_val_d  = lin_reload_val_q;
        lin_reload_flag_d = lin_reload_flag_q;
        linear_d          = linear_q;
        period_d          = period_q;
        timer_d           = timer_q;
        step_d            = step_q;

        if (wr_4008) begin
            ctrl_d           = reg_data[7];
            lin_reload_val_d = reg_data[6:0];
        end
        if (wr_400a)
            period_d[7:0] = reg_data;
        if (wr_400b)
            period_d[TIMER_W-1:8] = reg_data[TIMER_W-9:0];

        if (quarter_frame) begin
            if (lin_reload_flag_q)
                linear_d = lin_reload_val_q;
            else if (linear_q != 7'd0)
                linear_d = linear_q - 7'd1;
            if (!ctrl_q)
                lin_reload_flag_d = 1'b0;
        end
        // The write sets the flag after the quarter-frame update used the old one.
        if (wr_400b)
            lin_reload_flag_d = 1'b1;

        if (cpu_tick) begin
            if (timer_q == '0) begin
                timer_d = period_q;
                if (seq_run)
                    step_d = step_q + 5'd1;
            end else begin
                timer_d = timer_q - TIMER_W'(1);
            end
        end

        tr_out_d        = tri_seq(step_q);
        length_active_d = (length != 8'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q            <= 1'b0;
            lin_reload_val_q  <= 7'd0;
            lin_reload_flag_q <= 1'b0;
            linear_q          <= 7'd0;
            period_q          <= '0;
            timer_q           <= '0;
            step_q            <= 5'd0;
            tr_out_q          <= 4'd0;
            length_active_q   <= 1'b0;
        end else begin
            ctrl_q            <= ctrl_d;
            lin_reload_val_q  <= lin_reload_val_d;
            lin_reload_flag_q <= lin_reload_flag_d;
            linear_q          <= linear_d;
            period_q          <= period_d;
            timer_q           <= timer_d;
            step_q            <= step_d;
            tr_out_q          <= tr_out_d;
            length_active_q   <= length_active_d;
        end
    end

    assign tr_out        = tr_out_q;
    assign length_active = length_active_q;

endmodule

// File: tb/tb_triangle_channel.sv
// Directed bench for triangle_channel with a queue-based expected-value scoreboard.
module tb_triangle_channel;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_tick = 1'b0;
    logic       quarter_frame = 1'b0;
    logic       half_frame = 1'b0;
    logic       reg_wr = 1'b0;
    logic [1:0] reg_addr = 2'd0;
    logic [7:0] reg_data = 8'd0;
    logic       enable = 1'b0;
    logic [3:0] tr_out;
    logic       length_active;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    triangle_channel #(.TIMER_W(11)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_tick      (cpu_tick),
        .quarter_frame (quarter_frame),
        .half_frame    (half_frame),
        .reg_wr        (reg_wr),
        .reg_addr      (reg_addr),
        .reg_data      (reg_data),
        .enable        (enable),
        .tr_out        (tr_out),
        .length_active (length_active)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tri_model(input int s);
        int sm;
        sm = s % 32;
        return (sm < 16) ? 32'(15 - sm) : 32'(sm - 16);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed %0d expected <scoreboard empty>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] data);
        reg_wr   = 1'b1;
        reg_addr = addr;
        reg_data = data;
        cyc();
        reg_wr   = 1'b0;
    endtask

    task automatic pulse_qf();
        quarter_frame = 1'b1;
        cyc();
        quarter_frame = 1'b0;
    endtask

    task automatic pulse_hf();
        half_frame = 1'b1;
        cyc();
        half_frame = 1'b0;
    endtask

    task automatic ticks(input int n);
        cpu_tick = 1'b1;
        repeat (n) cyc();
        cpu_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        // Reset held 3 cycles
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("reset_tr_out", 32'(tr_out), 32'd0);
            check("reset_len_active", 32'(length_active), 32'd0);
        end
        reset = 1'b0;
        cyc();
        check("post_reset_tr_out", 32'(tr_out), 32'd15);
        check("post_reset_len_active", 32'(length_active), 32'd0);

        // Basic stepping: period 2, step every 3 ticks
        enable = 1'b1;
        wr(2'd0, 8'h81);
        wr(2'd2, 8'h02);
        wr(2'd3, 8'h08);
        pulse_qf();
        check("basic_len_active", 32'(length_active), 32'd1);
        check("basic_length", 32'(dut.u_len.length_q), 32'd254);
        check("basic_linear", 32'(dut.linear_q), 32'd1);
        for (int m = 0; m < 33; m++) exp_q.push_back(tri_model(m + 1));
        cpu_tick = 1'b1;
        for (int k = 0; k < 98; k++) begin
            cyc();
            if (k % 3 == 1) pop_check("step_tr_out", 32'(tr_out));
        end
        cpu_tick = 1'b0;

        // Linear counter expiry freezes the sequencer
        do_reset();
        wr(2'd0, 8'h03);
        wr(2'd2, 8'h02);
        wr(2'd3, 8'h08);
        exp_q.push_back(32'd3);
        pulse_qf();
        pop_check("linear_load", 32'(dut.linear_q));
        ticks(10);
        for (int p = 2; p >= 0; p--) begin
            exp_q.push_back(32'(p));
            pulse_qf();
            pop_check("linear_dec", 32'(dut.linear_q));
        end
        exp_q.push_back(32'd0);
        pulse_qf();
        pop_check("linear_no_reload", 32'(dut.linear_q));
        cyc();
        check("linear_freeze_a", 32'(tr_out), 32'd11);
        ticks(30);
        check("linear_freeze_b", 32'(tr_out), 32'd11);

        // Length counter expiry
        do_reset();
        wr(2'd0, 8'h7F);
        wr(2'd2, 8'h02);
        wr(2'd3, 8'h18);
        pulse_qf();
        check("len2_active", 32'(length_active), 32'd1);
        ticks(6);
        pulse_hf();
        pulse_hf();
        check("len_active_lag", 32'(length_active), 32'd1);
        cyc();
        check("len_expired", 32'(length_active), 32'd0);
        check("len_stop_a", 32'(tr_out), 32'd13);
        ticks(30);
        check("len_stop_b", 32'(tr_out), 32'd13);

        // Enable interactions
        do_reset();
        enable = 1'b0;
        wr(2'd3, 8'h08);
        cyc();
        check("disabled_load", 32'(length_active), 32'd0);
        enable = 1'b1;
        wr(2'd3, 8'h08);
        cyc();
        check("enabled_load", 32'(length_active), 32'd1);
        enable = 1'b0;
        cyc();
        cyc();
        check("enable_clear", 32'(length_active), 32'd0);
        enable = 1'b1;

        // $400B write coincident with half_frame: load wins
        wr(2'd0, 8'h00);
        half_frame = 1'b1;
        wr(2'd3, 8'h18);
        half_frame = 1'b0;
        check("collide_length", 32'(dut.u_len.length_q), 32'd2);
        pulse_hf();
        cyc();
        check("collide_hf1", 32'(length_active), 32'd1);
        pulse_hf();
        cyc();
        check("collide_hf2", 32'(length_active), 32'd0);

        // Ultrasonic guard: period 1 never steps
        do_reset();
        wr(2'd0, 8'h81);
        wr(2'd2, 8'h01);
        wr(2'd3, 8'h08);
        pulse_qf();
        check("ultra_linear", 32'(dut.linear_q), 32'd1);
        cpu_tick = 1'b1;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (k % 10 == 9) check("ultra_tr_out", 32'(tr_out), 32'd15);
        end

        // Reset mid-operation with strobes asserted
        quarter_frame = 1'b1;
        half_frame    = 1'b1;
        reset         = 1'b1;
        cyc();
        quarter_frame = 1'b0;
        half_frame    = 1'b0;
        cpu_tick      = 1'b0;
        check("midreset_tr_out", 32'(tr_out), 32'd0);
        check("midreset_len_active", 32'(length_active), 32'd0);
        check("midreset_linear", 32'(dut.linear_q), 32'd0);
        reset = 1'b0;
        cyc();
        check("midreset_release", 32'(tr_out), 32'd15);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/triangle_channel.md
# triangle_channel

NES APU triangle-wave generator: the upstream stage that drives the mixer's 4-bit triangle input (`tr_out`) alongside the square and noise generators. It implements the $4008/$400A/$400B register set, the 11-bit period timer, the 32-step triangle sequencer, the linear counter and the length counter. It is clocked by the system clock, advanced by CPU-rate and frame-sequencer strobes, and produces a registered 4-bit sample every cycle.

## Interface
Parameters:
- `TIMER_W`, 11: timer/period width.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `cpu_tick`, in, 1: single-cycle CPU-rate enable that clocks the timer.
- `quarter_frame`, in, 1: single-cycle frame-sequencer strobe that clocks the linear counter.
- `half_frame`, in, 1: single-cycle frame-sequencer strobe that clocks the length counter.
- `reg_wr`, in, 1: register write strobe.
- `reg_addr`, in, 2: 0 = $4008, 1 = $4009 (ignored), 2 = $400A, 3 = $400B.
- `reg_data`, in, 8: write data.
- `enable`, in, 1: $4015 bit 2, level.
- `tr_out`, out, 4: triangle sample to the mixer.
- `length_active`, out, 1: length counter ≠ 0, used for the $4015 read.

## Operation
- $4008 write: `ctrl` ← bit7 (also the length-halt flag); `lin_reload_val` ← bits 6:0.
- $400A write: `period[7:0]` ← data.
- $400B write:
  - `period[10:8]` ← bits 2:0.
  - Sets `lin_reload_flag`.
  - If `enable` = 1, `length` ← LENGTH_TABLE[bits 7:3]; otherwise `length` is unchanged.
- `enable` = 0 forces `length` to 0 on every cycle it is low.
- Timer, on `cpu_tick`:
  - If `timer` = 0: `timer` ← `period`. The sequencer advances (`step` ← `step` + 1, 5-bit wrap 31→0) only when `linear` ≠ 0, `length` ≠ 0 and `period` ≥ 2.
  - Else: `timer` ← `timer` − 1.
- Ultrasonic guard: with `period` < 2 the sequencer freezes and `tr_out` holds its current value.
- Sequence value: `step` < 16 gives 15 − `step`; otherwise `step` − 16. This yields 15…0 then 0…15.
- Linear counter, on `quarter_frame`:
  - If `lin_reload_flag`: `linear` ← `lin_reload_val`.
  - Else if `linear` ≠ 0: `linear` ← `linear` − 1.
  - Then, if `ctrl` = 0, clear `lin_reload_flag`.
- Length counter, on `half_frame`: if `ctrl` = 0 and `length` ≠ 0, `length` ← `length` − 1.
- A silenced channel (`linear` = 0 or `length` = 0) holds its last `tr_out` value. It does not drop to 0.

## Timing
- Reset values: `tr_out` = 0 and `length_active` = 0. All internal registers are 0, with `step` = 0.
- `tr_out` and `length_active` are registered.
  - `tr_out` reflects `step` one cycle after `step` changes, so it reads 15 on the first cycle after reset deassertion.
  - `length_active` reflects `length` one cycle after `length` changes.
- Register writes take effect on the next edge. A timer event in the same cycle as a write uses the old `period`.
- Simultaneous events:
  - $400B write and `half_frame` in the same cycle: the load wins and the decrement is dropped.
  - $400B write and `quarter_frame` in the same cycle: the linear update uses the pre-write flag, and the flag ends the cycle set.
  - `enable` = 0 with a $400B write or `half_frame`: `length` = 0 wins.
- `reset` asserted mid-operation returns everything to reset values on that edge. Strobes in the reset cycle are ignored.

## Structure
- Shared package `apu_pkg`:
  - LENGTH_TABLE[32] = {10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30}.
  - Register address constants for $4008, $4009, $400A and $400B.
- Sub-module `apu_length_counter`: table load, halt, enable clear and `half_frame` decrement. It is reused by the square and noise channels.

## Test plan
- Reset test: hold `reset` for 3 cycles, then release. Required: `tr_out` = 0 and `length_active` = 0 during reset; `tr_out` = 15 one cycle after release.
- Basic stepping:
  - Stimulus: `enable` = 1; write $4008 = 0x81, $400A = 0x02, $400B = 0x08; pulse `quarter_frame`; then drive `cpu_tick` every cycle.
  - Required: `length_active` = 1 (length = 254) and `linear` = 1.
  - Required: `tr_out` steps 15, 14, 13… once every 3 ticks, reaches 0, 0, then 1…15, and wraps back to 15.
- Linear expiry:
  - Stimulus: $4008 = 0x03; $400B = 0x08; 4 `quarter_frame` pulses.
  - Required: `linear` reads 3, 2, 1, 0; the sequencer freezes and `tr_out` holds.
  - Required: a 5th pulse does not reload, because the flag was cleared.
- Length expiry:
  - Stimulus: $4008 = 0x7F; $400B = 0x18 (index 3 → length 2); 2 `half_frame` pulses.
  - Required: `length_active` goes to 0 one cycle after the second pulse, and stepping stops.
- Enable and collision cases:
  - `enable` = 0 during a $400B write: `length_active` stays 0.
  - $400B write coincident with `half_frame`: `length` = table value with no decrement.
- Ultrasonic guard: $400A = 0x01, $400B = 0x08, `cpu_tick` for 100 cycles. Required: `tr_out` constant.
